neureka_streamer_sequencer: RTL

- Phase sequencer for the NEUREKA streamer. Per tile, it walks the shared TCDM path through the load phases and then the store phase: feat (or feat+weight), weight, norm, streamin, store.
- Drives the streamer's mux selects, clears and start pulses. Waits on the source/sink done flags, then on FIFO drain, before each switch.
- Sits between the NEUREKA controller FSM (tile start/done) and the streamer control struct.

---
 rtl/neureka_streamer_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/neureka_streamer_sequencer.sv
// -----------------------------------------------------------------------------
// neureka_streamer_sequencer
//
// Phase sequencer for the NEUREKA streamer. Each tile goes through its load
// phases and then the store phase on the shared TCDM path:
//   L0 (FEAT, or FEAT_WEIGHT when weights come from the weight port),
//   WEIGHT (only without the weight port), NORM (optional),
//   STREAMIN (optional), STORE.
// Every phase runs SETUP -> ISSUE -> WAIT -> DRAIN -> NEXT. That is at least
// 5 cycles per phase. Disabled phases take no cycles.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   clear_i              synchronous soft clear (same effect as reset)
//   start_i              job start, sampled only in IDLE
//   n_tiles_i            tiles in the job (0 is treated as 1)
//   wmem_sel_i           use the dedicated weight port (FEAT_WEIGHT phase)
//   norm_en_i            include the NORM phase
//   streamin_en_i        include the STREAMIN phase
//   src_done_i           source finished its address stream (pulse)
//   wsrc_done_i          weight-port source finished (pulse)
//   sink_done_i          sink finished (pulse)
//   fifo_empty_i         TCDM FIFO empty
//   ld_st_mux_sel_o      0 = load, 1 = store
//   ld_which_o           load phase select (0 FEAT .. 4 FEAT_WEIGHT)
//   wmem_sel_o           latched copy of wmem_sel_i
//   src_req_o            one-cycle source start pulse
//   sink_req_o           one-cycle sink start pulse
//   clear_source_o       one-cycle source clear pulse
//   clear_sink_o         one-cycle sink clear pulse
//   clear_fifo_o         one-cycle FIFO clear pulse (drain timeout)
//   tile_idx_o           current tile
//   busy_o               high when not IDLE
//   done_o               one-cycle pulse at job end
//   err_o                sticky drain-timeout flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module neureka_streamer_sequencer #(
  parameter int unsigned TILE_CNT_W    = 16,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [TILE_CNT_W-1:0] n_tiles_i,
  input  logic                  wmem_sel_i,
  input  logic                  norm_en_i,
  input  logic                  streamin_en_i,
  input  logic                  src_done_i,
  input  logic                  wsrc_done_i,
  input  logic                  sink_done_i,
  input  logic                  fifo_empty_i,
  output logic                  ld_st_mux_sel_o,
  output logic [2:0]            ld_which_o,
  output logic                  wmem_sel_o,
  output logic                  src_req_o,
  output logic                  sink_req_o,
  output logic                  clear_source_o,
  output logic                  clear_sink_o,
  output logic                  clear_fifo_o,
  output logic [TILE_CNT_W-1:0] tile_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_DRAIN, S_NEXT
  } state_e;

  // The load phase encodings match ld_which_o. STORE is internal only.
  typedef enum logic [2:0] {
    PH_FEAT        = 3'd0,
    PH_WEIGHT      = 3'd1,
    PH_NORM        = 3'd2,
    PH_STREAMIN    = 3'd3,
    PH_FEAT_WEIGHT = 3'd4,
    PH_STORE       = 3'd5
  } phase_e;

  // The drain counter only has to count up to DRAIN_TIMEOUT-1.
  localparam int unsigned DCNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST =
    DCNT_W'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
  localparam logic TIMEOUT_EN = (DRAIN_TIMEOUT != 0);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic                  phase_load;
  logic [TILE_CNT_W-1:0] n_last_q;
  logic                  wmem_q, norm_q, stin_q;
  logic [TILE_CNT_W-1:0] tile_q;
  logic                  done_seen_q, wsrc_seen_q;
  logic [DCNT_W-1:0]     dcnt_q;
  logic                  err_q;

  logic cfg_load, tile_clr, tile_inc, err_set;
  logic is_store, main_done_now, wait_met, timeout_hit, last_tile;

  // Load phases after cur, in fixed order. FEAT only occurs without the weight
  // port, so WEIGHT always follows it directly.
  function automatic phase_e after_phase(input phase_e cur, input logic nm,
                                         input logic si);
    phase_e nxt;
    nxt = PH_STORE;
    if (si && (cur inside {PH_FEAT, PH_FEAT_WEIGHT, PH_WEIGHT, PH_NORM})) nxt = PH_STREAMIN;
    if (nm && (cur inside {PH_FEAT, PH_FEAT_WEIGHT, PH_WEIGHT}))          nxt = PH_NORM;
    if (cur == PH_FEAT)                                                   nxt = PH_WEIGHT;
    return nxt;
  endfunction

  assign is_store      = (phase_q == PH_STORE);
  assign main_done_now = is_store ? sink_done_i : src_done_i;
  // A done in the current WAIT cycle counts as well as one captured earlier.
  // WAIT can then exit in its first cycle.
  assign wait_met      = (done_seen_q | main_done_now) &&
                         ((phase_q != PH_FEAT_WEIGHT) | wsrc_seen_q | wsrc_done_i);
  assign timeout_hit   = TIMEOUT_EN && !fifo_empty_i && (dcnt_q == DCNT_LAST);
  assign last_tile     = (tile_q == n_last_q);

  // NOTE: every signal gets a default at the top of the block, so a path that
  // does not assign it cannot infer a latch.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    phase_load     = 1'b0;
    cfg_load       = 1'b0;
    tile_clr       = 1'b0;
    tile_inc       = 1'b0;
    err_set        = 1'b0;
    src_req_o      = 1'b0;
    sink_req_o     = 1'b0;
    clear_source_o = 1'b0;
    clear_sink_o   = 1'b0;
    clear_fifo_o   = 1'b0;
    done_o         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_load   = 1'b1;
          tile_clr   = 1'b1;
          phase_d    = wmem_sel_i ? PH_FEAT_WEIGHT : PH_FEAT;
          phase_load = 1'b1;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        clear_source_o = !is_store;
        clear_sink_o   = is_store;
        state_d        = S_ISSUE;
      end
      S_ISSUE: begin
        src_req_o  = !is_store;
        sink_req_o = is_store;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_met) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // If the FIFO empties in the timeout cycle, the timeout does not count.
        if (fifo_empty_i) begin
          state_d = S_NEXT;
        end else if (timeout_hit) begin
          clear_fifo_o = 1'b1;
          err_set      = 1'b1;
          state_d      = S_NEXT;
        end
      end
      S_NEXT: begin
        phase_load = 1'b1;
        state_d    = S_SETUP;
        if (!is_store) begin
          phase_d = after_phase(phase_q, norm_q, stin_q);
        end else if (last_tile) begin
          done_o  = 1'b1;
          phase_d = PH_FEAT;  // so the selects read 0 again in IDLE
          state_d = S_IDLE;
        end else begin
          tile_inc = 1'b1;
          phase_d  = wmem_q ? PH_FEAT_WEIGHT : PH_FEAT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  // Flops then all update together at the edge, whatever the evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_FEAT;
      n_last_q    <= '0;
      wmem_q      <= 1'b0;
      norm_q      <= 1'b0;
      stin_q      <= 1'b0;
      tile_q      <= '0;
      done_seen_q <= 1'b0;
      wsrc_seen_q <= 1'b0;
      dcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (phase_load) phase_q <= phase_d;

      if (cfg_load) begin
        n_last_q <= (n_tiles_i == '0) ? '0 : n_tiles_i - TILE_CNT_W'(1);
        wmem_q   <= wmem_sel_i;
        norm_q   <= norm_en_i;
        stin_q   <= streamin_en_i;
      end

      if (tile_clr)      tile_q <= '0;
      else if (tile_inc) tile_q <= tile_q + TILE_CNT_W'(1);

      // Done pulses are captured only while the phase is in flight.
      if (state_q == S_SETUP) begin
        done_seen_q <= 1'b0;
        wsrc_seen_q <= 1'b0;
      end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
        if (main_done_now) done_seen_q <= 1'b1;
        if (wsrc_done_i)   wsrc_seen_q <= 1'b1;
      end

      if (state_q != S_DRAIN)                     dcnt_q <= '0;
      else if (TIMEOUT_EN && dcnt_q != DCNT_LAST) dcnt_q <= dcnt_q + DCNT_W'(1);

      if (cfg_load)     err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  assign ld_st_mux_sel_o = is_store;
  assign ld_which_o      = is_store ? 3'd0 : phase_q;
  assign wmem_sel_o      = wmem_q;
  assign tile_idx_o      = tile_q;
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = err_q;

endmodule
